seg_scan_driver_p: RTL and testbench
====================================

Name: seg_scan_driver_p

Overview:
- Parametrised next-generation multiplexed seven-segment driver for N common-anode digits.
- Accepts an unsigned binary value plus sign, converts it to BCD with a sequential double-dabble engine, and blanks leading zeros.
- Drives time-multiplexed digit selects with per-digit decimal point, per-digit blink, and 16-level brightness PWM.
- Sits between application logic (counters, measurement blocks) and board pins; it replaces the fixed 6-digit driver.

Parameters:
- DIGITS, 6, number of digits scanned (2..8).
- DATA_W, 20, width of binary input value.
- SLOT_CYCLES, 50000, sys_clk cycles per digit slot; must be a multiple of 16 (1 ms at 50 MHz).
- BLINK_SLOTS, 250, digit slots per blink half-period.
- CS_ACTIVE_LOW, 1, 1 = seg_cs active-low, 0 = active-high.

Ports:
- sys_clk  in  1  system clock; all logic runs on it (no derived clocks, clock-enable ticks only).
- sys_rst  in  1  reset, synchronous, active-high.
- load  in  1  single-cycle request to capture data/sign and start conversion.
- data  in  DATA_W  unsigned magnitude to display.
- sign  in  1  1 = show '-' left of the most significant digit.
- point  in  DIGITS  per-digit decimal point, 0 = lit.
- blink_mask  in  DIGITS  1 = digit blinks.
- brightness  in  4  duty level 0..15.
- seg_en  in  1  0 = all digits off.
- busy  out  1  conversion in progress.
- overflow  out  1  last converted value did not fit.
- seg_cs  out  DIGITS  digit selects; bit 0 = rightmost digit.
- seg_led  out  8  {dp, g..a}, active-low.

Behaviour:
- Reset values:
  - seg_cs all inactive; seg_led = 8'hFF; busy = 0; overflow = 0.
  - Display register shows blank except digit0 = '0'.
  - Scan index = 0; all counters = 0.
- Conversion handshake:
  - load while busy = 0 captures data and sign and sets busy the next cycle.
  - load while busy = 1 is ignored (no queueing).
  - Double-dabble runs DATA_W shift iterations, one per cycle, on an internal BCD register of BCD_N = (DATA_W*3)/10+1 digits.
  - Result is committed to the display register atomically on the cycle busy falls.
  - Total latency: busy high exactly DATA_W+1 cycles. The display shows the previous value until commit.
- Formatting at commit:
  - MSD = highest nonzero digit (digit 0 when value = 0).
  - Positions above the MSD are blank (code 10).
  - If sign = 1, position MSD+1 = '-' (code 11).
- Overflow:
  - Condition: any BCD digit at index >= DIGITS is nonzero, or sign = 1 and MSD = DIGITS-1.
  - Effect: overflow = 1 and all positions = '-'.
  - overflow is updated on every commit.
- Scanning:
  - Slot counter 0..SLOT_CYCLES-1; scan index advances 0..DIGITS-1 at each wrap, then returns to 0.
  - Each slot is split into 16 equal sub-phases. seg_cs for the current index is active while sub-phase <= brightness (level 15 = full slot, level 0 = 1/16 of slot); otherwise all inactive.
- Blink: a blink phase toggles every BLINK_SLOTS slots. During the off phase, digits with blink_mask = 1 output seg_led = 8'hFF.
- Segment codes:
  - 0-9 use the standard active-low patterns (0 = 8'hC0 with dp off).
  - Blank = 8'hFF; '-' = 8'hBF.
  - dp bit = point[index], forced to 1 for blank positions.
- Output timing: seg_cs and seg_led are registered together, one cycle after the scan counters change, so they never show mismatched index/data.
- seg_en = 0: seg_cs inactive and seg_led = 8'hFF from the next cycle. The counters and conversion keep running.
- Simultaneous events: a commit landing mid-slot takes effect on the next registered output. A change to brightness, point or blink_mask takes effect the next cycle.
- Reset asserted mid-conversion: aborts it, busy = 0, display returns to its reset contents.

Decomposition:
- Shared package seg_pkg holds:
  - segment code constants (SEG_BLANK, SEG_MINUS, 10-entry digit table);
  - digit code localparams CODE_BLANK = 10 and CODE_MINUS = 11;
  - a function for bcd-code-to-segment conversion.
- Sub-module bin2bcd_seq(DATA_W) implements the sequential double-dabble. Interface: start, bin, busy, done pulse, bcd.
- Formatting, scanning, PWM and blink logic stay in the top module.

Test Plan (DIGITS=6, DATA_W=20, SLOT_CYCLES=32, BLINK_SLOTS=4, brightness=15):
- load data=123456, sign=0 -> busy high 21 cycles. seg_led per slot 0..5 = 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9. seg_cs cycles 111110 -> 011111.
- load data=42, sign=1 -> digits 5..0 = FF, FF, FF, BF, 99, A4; overflow = 0.
- load data=0, sign=0 -> digit0 = 8'hC0, others 8'hFF. Then load 1048575 -> overflow = 1, all digits 8'hBF. Then load 100000 with sign=1 -> overflow = 1.
- brightness=0 -> seg_cs active 2 of 32 cycles per slot; brightness=7 -> 16 of 32; seg_en=0 -> seg_cs all 1 and seg_led = FF next cycle.
- blink_mask=000001, point=111110 -> digit0 alternates between its code with dp=0 and 8'hFF every 4 slots; other digits are steady.
- load during busy (second value 7) -> ignored, first value displayed. sys_rst asserted at busy cycle 10 -> busy = 0 next cycle and display = reset contents.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: digit codes, segment
// patterns (active-low {dp, g..a}) and the code-to-segment lookup.
package seg_pkg;

  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_MINUS = 4'd11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Entry n is the pattern for decimal digit n, dp off.
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  // Blank positions never light their decimal point.
  function automatic logic [7:0] seg_encode(input logic [3:0] code, input logic dp);
    logic [7:0] seg;
    if (code == CODE_BLANK)      seg = SEG_BLANK;
    else if (code == CODE_MINUS) seg = {dp, SEG_MINUS[6:0]};
    else if (code < 4'd10)       seg = {dp, SEG_DIGITS[code][6:0]};
    else                         seg = SEG_BLANK;
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_driver_p_if.sv
// Application/pin-side bundle of the scan driver; master = application
// logic and board, slave = the driver itself.
interface seg_scan_driver_p_if #(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
);
  logic              load;
  logic [DATA_W-1:0] data;
  logic              sign;
  logic [DIGITS-1:0] point;
  logic [DIGITS-1:0] blink_mask;
  logic [3:0]        brightness;
  logic              seg_en;
  logic              busy;
  logic              overflow;
  logic [DIGITS-1:0] seg_cs;
  logic [7:0]        seg_led;

  modport master (
    output load, data, sign, point, blink_mask, brightness, seg_en,
    input  busy, overflow, seg_cs, seg_led
  );

  modport slave (
    input  load, data, sign, point, blink_mask, brightness, seg_en,
    output busy, overflow, seg_cs, seg_led
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle for DATA_W cycles, then a
// one-cycle done pulse while the result in bcd is stable.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int BCD_N  = (DATA_W * 3) / 10 + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    bin,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_N*4-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  conv_state_t       state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] bin_sr;
  logic [BCD_N*4-1:0] adj;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= CONV_IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      CONV_IDLE:  if (start) state_next = CONV_SHIFT;
      CONV_SHIFT: if (cnt == CNT_W'(DATA_W - 1)) state_next = CONV_DONE;
      CONV_DONE:  state_next = CONV_IDLE;
      default:    state_next = CONV_IDLE;
    endcase
  end

  assign busy = (state != CONV_IDLE);
  assign done = (state == CONV_DONE);

  // Add-3 correction on every BCD digit of 5 or more before the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd    <= '0;
      bin_sr <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        CONV_IDLE: if (start) begin
          bin_sr <= bin;
          bcd    <= '0;
          cnt    <= '0;
        end
        CONV_SHIFT: begin
          bcd    <= {adj[BCD_N*4-2:0], bin_sr[DATA_W-1]};
          bin_sr <= {bin_sr[DATA_W-2:0], 1'b0};
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver_p.sv
// Multiplexed common-anode seven-segment driver: binary+sign to formatted
// digits, time-multiplexed scanning with brightness PWM, blink and dp.
module seg_scan_driver_p
  import seg_pkg::*;
#(
  parameter int DIGITS        = 6,
  parameter int DATA_W        = 20,
  parameter int SLOT_CYCLES   = 50000,
  parameter int BLINK_SLOTS   = 250,
  parameter bit CS_ACTIVE_LOW = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  seg_scan_driver_p_if.slave bus
);

  localparam int BCD_N     = (DATA_W * 3) / 10 + 1;
  localparam int PHASE_LEN = SLOT_CYCLES / 16;
  localparam int PH_W      = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int IDX_W     = $clog2(DIGITS);
  localparam int BL_W      = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [DIGITS-1:0] CS_IDLE = CS_ACTIVE_LOW ? '1 : '0;

  logic               conv_busy, conv_done, start, sign_q;
  logic [BCD_N*4-1:0] conv_bcd;

  assign start = bus.load && !conv_busy;

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_N(BCD_N)) u_bin2bcd (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (start),
    .bin   (bus.data),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst)    sign_q <= 1'b0;
    else if (start) sign_q <= bus.sign;
  end

  // ---------------- formatting of the finished conversion ----------------
  int         msd;
  logic       fmt_ovf;
  logic [3:0] fmt_code [DIGITS];

  always_comb begin
    msd     = 0;
    fmt_ovf = 1'b0;
    for (int i = 0; i < BCD_N; i++)
      if (conv_bcd[4*i +: 4] != 4'd0) msd = i;
    for (int i = DIGITS; i < BCD_N; i++)
      if (conv_bcd[4*i +: 4] != 4'd0) fmt_ovf = 1'b1;
    // A sign with a full-width value has nowhere to go.
    if (sign_q && msd == DIGITS - 1) fmt_ovf = 1'b1;
    for (int p = 0; p < DIGITS; p++) begin
      if (fmt_ovf)                      fmt_code[p] = CODE_MINUS;
      else if (p <= msd)                fmt_code[p] = conv_bcd[4*p +: 4];
      else if (sign_q && p == msd + 1)  fmt_code[p] = CODE_MINUS;
      else                              fmt_code[p] = CODE_BLANK;
    end
  end

  logic [3:0] disp [DIGITS];
  logic       ovf_q;

  // NOTE: the display array is a handful of flops, not a RAM, so it is
  // reset explicitly to show a lone '0' out of reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int p = 0; p < DIGITS; p++) disp[p] <= (p == 0) ? 4'd0 : CODE_BLANK;
      ovf_q <= 1'b0;
    end else if (conv_done) begin
      disp  <= fmt_code;
      ovf_q <= fmt_ovf;
    end
  end

  assign bus.busy     = conv_busy;
  assign bus.overflow = ovf_q;

  // ---------------- slot / sub-phase / blink timing ----------------
  // The slot counter is kept as (sub_phase, phase_cnt) so the PWM compare
  // needs no divider.
  logic [PH_W-1:0]  phase_cnt;
  logic [3:0]       sub_phase;
  logic [IDX_W-1:0] scan_idx;
  logic [BL_W-1:0]  blink_cnt;
  logic             blink_off;
  logic             phase_wrap, slot_wrap;

  assign phase_wrap = (phase_cnt == PH_W'(PHASE_LEN - 1));
  assign slot_wrap  = phase_wrap && (sub_phase == 4'hF);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      phase_cnt <= '0;
      sub_phase <= '0;
      scan_idx  <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      phase_cnt <= phase_wrap ? '0 : phase_cnt + 1'b1;
      if (phase_wrap) sub_phase <= sub_phase + 1'b1;
      if (slot_wrap) begin
        scan_idx <= (scan_idx == IDX_W'(DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        if (blink_cnt == BL_W'(BLINK_SLOTS - 1)) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- registered pin outputs ----------------
  logic [DIGITS-1:0] sel;
  assign sel = DIGITS'(1) << scan_idx;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !bus.seg_en) begin
      bus.seg_cs  <= CS_IDLE;
      bus.seg_led <= SEG_BLANK;
    end else begin
      bus.seg_cs  <= (sub_phase <= bus.brightness) ? (sel ^ CS_IDLE) : CS_IDLE;
      bus.seg_led <= (blink_off && bus.blink_mask[scan_idx]) ? SEG_BLANK
                   : seg_encode(disp[scan_idx], bus.point[scan_idx]);
    end
  end

endmodule

// File: tb/tb_seg_scan_driver_p.sv
// Self-checking bench: cycle-level behavioural model of the display plus
// directed literal checks and randomized conversions.
module tb_seg_scan_driver_p;

  localparam int DIGITS = 6;
  localparam int DATA_W = 20;
  localparam int SLOT   = 32;
  localparam int BLINK  = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  seg_scan_driver_p_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  seg_scan_driver_p #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .SLOT_CYCLES(SLOT),
    .BLINK_SLOTS(BLINK), .CS_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  bit          m_valid = 1'b0;
  int          m_t;
  bit          m_busy;
  int          m_rem;
  int unsigned m_pend_v;
  bit          m_pend_s;
  int          m_code [DIGITS];
  bit          m_ovf;
  int          m_idx, m_sub, m_c;
  bit          m_blink_off;
  logic [DIGITS-1:0] e_cs;
  logic [7:0]  e_led;
  bit          e_busy, e_ovf;

  // Decimal formatting straight from the display rules.
  function automatic void model_format(input int unsigned v, input bit s);
    int unsigned x;
    int n;
    n = 1;
    x = v;
    while (x >= 10) begin x = x / 10; n++; end
    m_ovf = (n > DIGITS) || (s && n == DIGITS);
    x = v;
    for (int p = 0; p < DIGITS; p++) begin
      if (m_ovf)              m_code[p] = 11;
      else if (p < n)         m_code[p] = int'(x % 10);
      else if (s && p == n)   m_code[p] = 11;
      else                    m_code[p] = 10;
      x = x / 10;
    end
  endfunction

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_t = 0; m_busy = 1'b0; m_rem = 0;
      model_format(0, 1'b0);
      e_cs = '1; e_led = 8'hFF;
      m_valid = 1'b1;
    end else begin
      m_idx = (m_t / SLOT) % DIGITS;
      m_sub = (m_t % SLOT) / (SLOT / 16);
      m_blink_off = ((m_t / (SLOT * BLINK)) % 2) == 1;
      m_c = m_code[m_idx];
      if (!bus.seg_en) begin
        e_cs = '1; e_led = 8'hFF;
      end else begin
        e_cs = (m_sub <= int'(bus.brightness)) ? ~(DIGITS'(1) << m_idx) : '1;
        if (m_blink_off && bus.blink_mask[m_idx]) e_led = 8'hFF;
        else if (m_c == 10) e_led = 8'hFF;
        else if (m_c == 11) e_led = {bus.point[m_idx], 7'h3F};
        else                e_led = {bus.point[m_idx], seg_tab[m_c][6:0]};
      end
      m_t++;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          model_format(m_pend_v, m_pend_s);
        end
      end else if (bus.load) begin
        m_busy = 1'b1;
        m_rem = DATA_W + 1;
        m_pend_v = bus.data;
        m_pend_s = bus.sign;
      end
    end
    e_busy = m_busy;
    e_ovf  = m_ovf;
  end

  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("seg_cs",   bus.seg_cs,   e_cs);
      check("seg_led",  bus.seg_led,  e_led);
      check("busy",     bus.busy,     e_busy);
      check("overflow", bus.overflow, e_ovf);
    end
  end

  // ---------------- directed helpers ----------------
  logic [7:0] frame [DIGITS];

  task automatic do_load(input int unsigned v, input bit s);
    bus.data = DATA_W'(v);
    bus.sign = s;
    bus.load = 1'b1;
    @(negedge sys_clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge sys_clk);
    end
    if (cyc >= 200) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic capture_frame();
    for (int i = 0; i < DIGITS; i++) frame[i] = 8'h00;
    for (int c = 0; c < SLOT * DIGITS + 4; c++) begin
      @(negedge sys_clk);
      for (int i = 0; i < DIGITS; i++)
        if (bus.seg_cs == ~(DIGITS'(1) << i)) frame[i] = bus.seg_led;
    end
  endtask

  task automatic check_frame(input string name, input logic [DIGITS*8-1:0] exp);
    capture_frame();
    for (int i = 0; i < DIGITS; i++) check(name, frame[i], exp[8*i +: 8]);
  endtask

  task automatic count_active(input int cycles, output int act);
    act = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge sys_clk);
      if (bus.seg_cs != '1) act++;
    end
  endtask

  int cyc, act, on_cnt, off_cnt, other_lit;

  initial begin
    bus.load = 1'b0; bus.data = '0; bus.sign = 1'b0;
    bus.point = '1; bus.blink_mask = '0; bus.brightness = 4'd15; bus.seg_en = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    check("rst_busy", bus.busy, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    check_frame("rst_frame", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    do_load(123456, 1'b0);
    wait_idle(cyc);
    check("busy_len", cyc, 21);
    check_frame("f123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    do_load(42, 1'b1);
    wait_idle(cyc);
    check("ovf_42", bus.overflow, 1'b0);
    check_frame("fneg42", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h99, 8'hA4});

    do_load(0, 1'b0);
    wait_idle(cyc);
    check_frame("fzero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    do_load(1048575, 1'b0);
    wait_idle(cyc);
    check("ovf_max", bus.overflow, 1'b1);
    check_frame("fmax", {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF});

    do_load(100000, 1'b1);
    wait_idle(cyc);
    check("ovf_sign6", bus.overflow, 1'b1);

    // Reset at busy cycle 10 aborts the conversion.
    do_load(555555, 1'b0);
    repeat (9) @(negedge sys_clk);
    check("busy_mid", bus.busy, 1'b1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_ovf", bus.overflow, 1'b0);
    sys_rst = 1'b0;
    check_frame("rst_mid_frame", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    // Blink on digit0 with its decimal point lit.
    bus.point = 6'b111110;
    bus.blink_mask = 6'b000001;
    on_cnt = 0; off_cnt = 0; other_lit = 0;
    for (int c = 0; c < SLOT * 48; c++) begin
      @(negedge sys_clk);
      if (bus.seg_cs == 6'b111110) begin
        if (bus.seg_led == 8'h40) on_cnt++;
        else if (bus.seg_led == 8'hFF) off_cnt++;
      end
      if (bus.seg_cs == 6'b111101 && bus.seg_led != 8'hFF) other_lit++;
    end
    check("blink_on_seen", on_cnt > 0, 1'b1);
    check("blink_off_seen", off_cnt > 0, 1'b1);
    check("blink_other_steady", other_lit, 0);
    bus.point = '1;
    bus.blink_mask = '0;

    bus.brightness = 4'd0;
    repeat (2) @(negedge sys_clk);
    count_active(SLOT * DIGITS, act);
    check("bright0", act, 2 * DIGITS);
    bus.brightness = 4'd7;
    repeat (2) @(negedge sys_clk);
    count_active(SLOT * DIGITS, act);
    check("bright7", act, 16 * DIGITS);
    bus.brightness = 4'd15;

    bus.seg_en = 1'b0;
    @(negedge sys_clk);
    check("en_off_cs", bus.seg_cs, 6'h3F);
    check("en_off_led", bus.seg_led, 8'hFF);
    bus.seg_en = 1'b1;

    // A second load during busy is dropped.
    do_load(123, 1'b0);
    repeat (3) @(negedge sys_clk);
    do_load(7, 1'b0);
    wait_idle(cyc);
    check_frame("f123_ignore7", {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0});

    // Randomized conversions and display controls against the model.
    for (int it = 0; it < 30; it++) begin
      int unsigned v;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(0, 999999);
        default: v = $urandom_range(0, 1048575);
      endcase
      bus.point      = DIGITS'($urandom);
      bus.blink_mask = DIGITS'($urandom);
      bus.brightness = 4'($urandom);
      bus.seg_en     = ($urandom_range(0, 7) != 0);
      do_load(v, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 15)) @(negedge sys_clk);
        do_load($urandom_range(0, 1048575), 1'($urandom));
      end
      wait_idle(cyc);
      repeat ($urandom_range(0, 300)) @(negedge sys_clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
